gpio_mmio_responder: RTL and testbench
======================================

Name: gpio_mmio_responder

Overview:
Memory-mapped GPIO peripheral that answers the multi-cycle MIPS core's data-memory bus accesses to the GPIO address window. It holds the output register driving GPIO_o, synchronizes GPIO_i, and latches rising edges in sticky status bits. It sits beside data memory in Data_Path; the core initiates accesses, and this block decodes, responds and returns read data.

Parameters:
DATA_WIDTH, 32, bus data/address width
GPIO_WIDTH, 8, number of GPIO in and out pins
BASE_ADDR, 32'h1001_0024, byte address of register offset 0x00

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
Address  input  DATA_WIDTH  byte address from the core; bits [1:0] ignored
Write_Data  input  DATA_WIDTH  store data
Mem_Write  input  1  store strobe, one cycle
Mem_Read  input  1  load strobe, one cycle
Hit  output  1  combinational: Address inside the window [BASE_ADDR, BASE_ADDR+0x1C]
Read_Data  output  DATA_WIDTH  registered load data
Read_Valid  output  1  high for one cycle when Read_Data is valid
GPIO_i  input  GPIO_WIDTH  asynchronous external inputs
GPIO_o  output  GPIO_WIDTH  output register
Edge_IRQ  output  1  registered: high when any (EDGE & EDGE_EN) bit is set

Behaviour:
- Register map (offset, access):
  - 0x00 OUT, RW.
  - 0x04 OUT_SET, W: OUT |= wd.
  - 0x08 OUT_CLR, W: OUT &= ~wd.
  - 0x0C OUT_TGL, W: OUT ^= wd.
  - 0x10 IN, R: synchronized input.
  - 0x14 EDGE, R/W1C: sticky rising-edge flags.
  - 0x18 EDGE_EN, RW: interrupt mask.
  - 0x1C, reserved: reads return 0, writes ignored.
- Only bits [GPIO_WIDTH-1:0] are used. Upper read bits = 0. Upper write bits are ignored.
- Reset: OUT, EDGE, EDGE_EN, both sync stages, and the previous-sample register = 0. Read_Data = 0, Read_Valid = 0, Edge_IRQ = 0, GPIO_o = 0.
  - Reset wins over any simultaneous access.
  - A read in flight when reset asserts produces no Read_Valid.
- Writes: take effect on the clk edge where Mem_Write && Hit. The new value is visible on GPIO_o the next cycle.
  - Mem_Write without Hit: no state change.
  - Writes to read-only offsets (0x10) are ignored.
- Reads: latency 1.
  - Mem_Read && Hit in cycle N gives Read_Data valid and Read_Valid = 1 in cycle N+1.
  - Read_Data holds its value until the next hit read.
  - Read_Valid is 0 otherwise, and Read_Data is not updated.
  - Mem_Read without Hit: no response.
- Read and write to the same address in the same cycle: the read returns the pre-write value. The write still applies.
- Read-only values:
  - IN returns the 2nd synchronizer stage. An input change appears in IN 2 clocks after it is sampled.
  - EDGE read has no side effect.
- Input path: sync1 <= GPIO_i; sync2 <= sync1; prev <= sync2.
- Edge detect: rise = sync2 & ~prev. The first edge can be flagged 3 cycles after the pin rises.
- EDGE update per bit: next = (EDGE & ~w1c_mask) | rise.
  - w1c_mask = Write_Data on a hit write to 0x14, else 0.
  - A new rise in the same cycle as a clear leaves the bit set (set wins).
- Edge_IRQ <= |(next_EDGE & next_EDGE_EN). This is one cycle after the corresponding EDGE/EDGE_EN update.
- Falling edges and held-high levels do not set EDGE. A bit clears only by W1C or reset.
- No wait states: the block always accepts. Back-to-back reads in consecutive cycles give consecutive Read_Valid pulses.

Test Plan:
- Reset: drive GPIO_i = 8'hFF with reset high for 3 cycles -> GPIO_o = 0, Read_Valid = 0, Edge_IRQ = 0; after release, a read of EDGE returns 0 until the synchronizer delay has elapsed.
- Writes:
  - Write 0xA5 to OUT -> GPIO_o = 8'hA5 the next cycle.
  - SET 0x0F -> 8'hAF; CLR 0xA0 -> 8'h0F; TGL 0xFF -> 8'hF0.
  - A write of 0xFFFF_FF00 leaves the low byte unchanged.
- Read handshake:
  - Mem_Read at BASE_ADDR+0x00 in cycle N -> Read_Valid = 1 and Read_Data = 32'h0000_00F0 in N+1 only.
  - Read at BASE_ADDR+0x20 -> Hit = 0, no Read_Valid.
  - Address BASE_ADDR+0x03 aliases offset 0x00.
- Edge capture:
  - GPIO_i 0x00 -> 0x81 -> EDGE = 0x81 within 3 cycles; a falling edge back to 0x00 keeps 0x81.
  - EDGE_EN = 0x01 -> Edge_IRQ = 1.
  - W1C 0x01 -> EDGE = 0x80, Edge_IRQ = 0 the cycle after.
- Clear/rise collision: W1C 0x02 on the same edge that bit 1's rise is detected -> EDGE[1] stays 1.
- Simultaneous access and reset:
  - Read and write 0x3C to OUT in the same cycle -> Read_Data returns the old OUT value; GPIO_o = 0x3C.
  - Reset asserted the cycle after a hit read -> Read_Valid stays 0 and all registers are 0.

Source files
------------

// File: rtl/gpio_mmio_responder_if.sv
// Data-memory bus seen by the GPIO responder: core-driven address/strobes,
// responder-driven hit flag and registered read return.
interface gpio_mmio_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] Write_Data;
  logic                  Mem_Write;
  logic                  Mem_Read;
  logic                  Hit;
  logic [DATA_WIDTH-1:0] Read_Data;
  logic                  Read_Valid;

  modport master (
    output Address, Write_Data, Mem_Write, Mem_Read,
    input  Hit, Read_Data, Read_Valid
  );

  modport slave (
    input  Address, Write_Data, Mem_Write, Mem_Read,
    output Hit, Read_Data, Read_Valid
  );
endinterface

// File: rtl/gpio_mmio_responder.sv
// Memory-mapped GPIO block: output register with set/clear/toggle aliases,
// two-stage input synchronizer, sticky W1C rising-edge flags and a masked IRQ.
module gpio_mmio_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    GPIO_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h1001_0024
) (
  input  logic                  clk,
  input  logic                  reset,
  gpio_mmio_responder_if.slave  bus,
  input  logic [GPIO_WIDTH-1:0] GPIO_i,
  output logic [GPIO_WIDTH-1:0] GPIO_o,
  output logic                  Edge_IRQ
);

  localparam logic [DATA_WIDTH-1:0] WIN_SPAN = DATA_WIDTH'(32'h20);

  localparam logic [2:0] SEL_OUT  = 3'd0;
  localparam logic [2:0] SEL_SET  = 3'd1;
  localparam logic [2:0] SEL_CLR  = 3'd2;
  localparam logic [2:0] SEL_TGL  = 3'd3;
  localparam logic [2:0] SEL_IN   = 3'd4;
  localparam logic [2:0] SEL_EDGE = 3'd5;
  localparam logic [2:0] SEL_EN   = 3'd6;

  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] edge_q, edge_d;
  logic [GPIO_WIDTH-1:0] en_q, en_d;
  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  logic [DATA_WIDTH-1:0] offset_s;
  logic                  hit_s;
  logic [2:0]            sel_s;
  logic [GPIO_WIDTH-1:0] wd_s;
  logic [GPIO_WIDTH-1:0] w1c_s;
  logic [GPIO_WIDTH-1:0] rise_s;
  logic [GPIO_WIDTH-1:0] rd_gpio_s;
  logic                  unused_wd_s;

  // BASE_ADDR is word aligned, so the unsigned difference covers both window
  // bounds and lets Address[1:0] alias onto the same register.
  assign offset_s    = bus.Address - BASE_ADDR;
  assign hit_s       = (offset_s < WIN_SPAN);
  assign sel_s       = offset_s[4:2];
  assign wd_s        = bus.Write_Data[GPIO_WIDTH-1:0];
  assign unused_wd_s = ^bus.Write_Data[DATA_WIDTH-1:GPIO_WIDTH];
  assign rise_s      = sync2_q & ~prev_q;

  // Register writes, W1C mask, edge/IRQ next state and read mux.
  always_comb begin
    out_d     = out_q;
    en_d      = en_q;
    w1c_s     = '0;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    rd_gpio_s = '0;

    if (bus.Mem_Write && hit_s) begin
      case (sel_s)
        SEL_OUT:  out_d = wd_s;
        SEL_SET:  out_d = out_q | wd_s;
        SEL_CLR:  out_d = out_q & ~wd_s;
        SEL_TGL:  out_d = out_q ^ wd_s;
        SEL_EDGE: w1c_s = wd_s;
        SEL_EN:   en_d  = wd_s;
        default:  out_d = out_q;
      endcase
    end else begin
      out_d = out_q;
    end

    // Set wins: a rise in the clearing cycle re-asserts the bit.
    edge_d = (edge_q & ~w1c_s) | rise_s;
    irq_d  = |(edge_d & en_d);

    if (bus.Mem_Read && hit_s) begin
      case (sel_s)
        SEL_OUT:  rd_gpio_s = out_q;
        SEL_IN:   rd_gpio_s = sync2_q;
        SEL_EDGE: rd_gpio_s = edge_q;
        SEL_EN:   rd_gpio_s = en_q;
        default:  rd_gpio_s = '0;
      endcase
      rdata_d  = {{(DATA_WIDTH-GPIO_WIDTH){1'b0}}, rd_gpio_s};
      rvalid_d = 1'b1;
    end else begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
    end
  end

  // State registers and input synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= '0;
      edge_q   <= '0;
      en_q     <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      edge_q   <= edge_d;
      en_q     <= en_d;
      sync1_q  <= GPIO_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // A response pending when reset rises must not reach the core.
  assign bus.Hit        = hit_s;
  assign bus.Read_Data  = rdata_q;
  assign bus.Read_Valid = rvalid_q & ~reset;
  assign GPIO_o         = out_q;
  assign Edge_IRQ       = irq_q;

endmodule

// File: tb/tb_gpio_mmio_responder.sv
// Directed bench for gpio_mmio_responder: register map, read handshake,
// edge capture, W1C/rise collision and reset interaction.
module tb_gpio_mmio_responder;

  localparam logic [31:0] BASE = 32'h1001_0024;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gpio_i;
  logic [7:0] gpio_o;
  logic       irq;
  int         total = 0;
  int         bad   = 0;

  gpio_mmio_responder_if #(.DATA_WIDTH(32)) bus_if ();

  gpio_mmio_responder #(
    .DATA_WIDTH(32),
    .GPIO_WIDTH(8),
    .BASE_ADDR (32'h1001_0024)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .GPIO_i  (gpio_i),
    .GPIO_o  (gpio_o),
    .Edge_IRQ(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    bus_if.Address    = BASE + off;
    bus_if.Write_Data = d;
    bus_if.Mem_Write  = 1'b1;
    tick();
    bus_if.Mem_Write  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string tag);
    bus_if.Address  = BASE + off;
    bus_if.Mem_Read = 1'b1;
    #1;
    chk({tag, "_hit"}, {31'd0, bus_if.Hit}, 32'd1);
    tick();
    bus_if.Mem_Read = 1'b0;
    chk({tag, "_rv"}, {31'd0, bus_if.Read_Valid}, 32'd1);
    chk({tag, "_rd"}, bus_if.Read_Data, exp);
    tick();
    chk({tag, "_rv_drop"}, {31'd0, bus_if.Read_Valid}, 32'd0);
    chk({tag, "_hold"}, bus_if.Read_Data, exp);
  endtask

  initial begin
    reset             = 1'b1;
    gpio_i            = 8'hFF;
    bus_if.Address    = BASE;
    bus_if.Write_Data = 32'd0;
    bus_if.Mem_Write  = 1'b0;
    bus_if.Mem_Read   = 1'b0;

    // Reset with inputs high
    tick(); tick(); tick();
    chk("rst_gpio_o", {24'd0, gpio_o}, 32'd0);
    chk("rst_rv", {31'd0, bus_if.Read_Valid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", bus_if.Read_Data, 32'd0);
    reset = 1'b0;
    rd(32'h14, 32'd0, "edge_post_rst");
    tick(); tick(); tick();
    rd(32'h14, 32'h0000_00FF, "edge_sync_ff");
    gpio_i = 8'h00;
    tick(); tick(); tick(); tick();
    wr(32'h14, 32'h0000_00FF);
    rd(32'h14, 32'd0, "edge_cleared");

    // Output register and its aliases
    wr(32'h00, 32'h0000_00A5); chk("out_wr", {24'd0, gpio_o}, 32'h0000_00A5);
    wr(32'h04, 32'h0000_000F); chk("out_set", {24'd0, gpio_o}, 32'h0000_00AF);
    wr(32'h08, 32'h0000_00A0); chk("out_clr", {24'd0, gpio_o}, 32'h0000_000F);
    wr(32'h0C, 32'h0000_00FF); chk("out_tgl", {24'd0, gpio_o}, 32'h0000_00F0);
    wr(32'h04, 32'hFFFF_FF00); chk("out_upper", {24'd0, gpio_o}, 32'h0000_00F0);
    wr(32'h10, 32'h0000_00FF); chk("wr_in_ign", {24'd0, gpio_o}, 32'h0000_00F0);
    wr(32'h1C, 32'h0000_00FF); chk("wr_rsv_ign", {24'd0, gpio_o}, 32'h0000_00F0);
    wr(32'h20, 32'h0000_0011); chk("wr_miss_ign", {24'd0, gpio_o}, 32'h0000_00F0);

    // Read handshake and decode
    rd(32'h00, 32'h0000_00F0, "rd_out");
    rd(32'h03, 32'h0000_00F0, "rd_alias");
    rd(32'h1C, 32'd0, "rd_rsv");
    rd(32'h10, 32'd0, "rd_in");
    bus_if.Address  = BASE + 32'h20;
    bus_if.Mem_Read = 1'b1;
    #1;
    chk("miss_hi_hit", {31'd0, bus_if.Hit}, 32'd0);
    tick();
    bus_if.Mem_Read = 1'b0;
    chk("miss_hi_rv", {31'd0, bus_if.Read_Valid}, 32'd0);
    chk("miss_hi_hold", bus_if.Read_Data, 32'd0);
    bus_if.Address = BASE - 32'd4;
    #1;
    chk("miss_lo_hit", {31'd0, bus_if.Hit}, 32'd0);

    // Edge capture, falling edge ignored, IRQ mask and W1C
    gpio_i = 8'h81;
    tick(); tick(); tick();
    rd(32'h14, 32'h0000_0081, "edge_81");
    gpio_i = 8'h00;
    tick(); tick(); tick();
    rd(32'h14, 32'h0000_0081, "edge_fall");
    chk("irq_masked", {31'd0, irq}, 32'd0);
    wr(32'h18, 32'h0000_0001); chk("irq_on", {31'd0, irq}, 32'd1);
    wr(32'h14, 32'h0000_0001); chk("irq_off", {31'd0, irq}, 32'd0);
    rd(32'h14, 32'h0000_0080, "edge_w1c");
    rd(32'h18, 32'h0000_0001, "rd_en");

    // Clear and rise of bit 1 on the same edge
    gpio_i = 8'h02;
    tick(); tick();
    wr(32'h14, 32'h0000_0002);
    rd(32'h14, 32'h0000_0082, "edge_collide");
    wr(32'h14, 32'h0000_0082);
    rd(32'h14, 32'd0, "edge_clr_all");
    rd(32'h10, 32'h0000_0002, "rd_in_02");

    // Read and write to OUT in the same cycle
    bus_if.Address    = BASE;
    bus_if.Write_Data = 32'h0000_003C;
    bus_if.Mem_Write  = 1'b1;
    bus_if.Mem_Read   = 1'b1;
    tick();
    bus_if.Mem_Write  = 1'b0;
    bus_if.Mem_Read   = 1'b0;
    chk("rw_rv", {31'd0, bus_if.Read_Valid}, 32'd1);
    chk("rw_old", bus_if.Read_Data, 32'h0000_00F0);
    chk("rw_new", {24'd0, gpio_o}, 32'h0000_003C);

    // Reset the cycle after a hit read
    gpio_i = 8'h03;
    tick(); tick(); tick();
    chk("irq_pre_rst", {31'd0, irq}, 32'd1);
    bus_if.Address  = BASE;
    bus_if.Mem_Read = 1'b1;
    tick();
    bus_if.Mem_Read = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_kill_rv", {31'd0, bus_if.Read_Valid}, 32'd0);
    tick();
    chk("rst2_gpio_o", {24'd0, gpio_o}, 32'd0);
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    chk("rst2_rv", {31'd0, bus_if.Read_Valid}, 32'd0);
    chk("rst2_rdata", bus_if.Read_Data, 32'd0);
    gpio_i = 8'h00;
    reset  = 1'b0;
    rd(32'h14, 32'd0, "rst2_edge");
    rd(32'h18, 32'd0, "rst2_en");
    rd(32'h00, 32'd0, "rst2_out");
    rd(32'h10, 32'd0, "rst2_in");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
